// File: rtl/bsg_manycore_npa_to_eva.sv
// Translates a network physical address (x/y cord + word EPA) back into the 32-bit endpoint virtual address.
// Latency 1: an NPA accepted on cycle N is presented on v_o/eva_o in cycle N+1.
// Backpressure: one-entry stage; ready_o = ~v_o | yumi_i, so a consumed entry is replaced with no bubble.
//
// Ports:
//   clk_i, reset_i            clock, synchronous active-high reset
//   v_i/ready_o               input handshake; x_cord_i, y_cord_i, epa_i form the NPA
//   tgo_x_i/tgo_y_i           tile-group origin, sampled with the transfer
//   tg_dim_x_i/tg_dim_y_i     tile-group dimensions, sampled with the transfer
//   dram_enable_i             DRAM striping mode, sampled with the transfer
//   v_o/yumi_i                output handshake; eva_o, is_invalid_o form the result
//   invalid_count_o           saturating count of invalid results consumed
//
// Optional feature: define BSG_MANYCORE_NPA_TO_EVA_TG_EN to recover tile-group
// relative EVAs; without it tile NPAs are always returned in global form and the
// tile-group inputs are ignored.

module bsg_manycore_npa_to_eva #(
    parameter int data_width_p   = 32,
    parameter int addr_width_p   = 28,
    parameter int x_cord_width_p = 7,
    parameter int y_cord_width_p = 7,
    parameter int num_tiles_y_p  = 4,
    parameter int vcache_size_p  = 1024
) (
    input  logic                      clk_i,
    input  logic                      reset_i,

    input  logic                      v_i,
    input  logic [x_cord_width_p-1:0] x_cord_i,
    input  logic [y_cord_width_p-1:0] y_cord_i,
    input  logic [addr_width_p-1:0]   epa_i,
    output logic                      ready_o,

    input  logic [x_cord_width_p-1:0] tgo_x_i,
    input  logic [y_cord_width_p-1:0] tgo_y_i,
    input  logic [x_cord_width_p-1:0] tg_dim_x_i,
    input  logic [y_cord_width_p-1:0] tg_dim_y_i,
    input  logic                      dram_enable_i,

    output logic                      v_o,
    output logic [31:0]               eva_o,
    output logic                      is_invalid_o,
    input  logic                      yumi_i,
    output logic [7:0]                invalid_count_o
);

    localparam int lg_vcache_size_lp = $clog2(vcache_size_p);
    // Bit that distinguishes the bottom vcache row from the top one in DRAM EVAs.
    localparam int bot_bit_lp        = 2 + lg_vcache_size_lp + x_cord_width_p;

    logic        is_host;
    logic        is_dram;
    logic        dram_epa_ok;
    logic        epa_lo_ok;
    logic        glb_ok;
    logic        tg_hit;
    logic [31:0] host_eva;
    logic [31:0] dram_eva;
    logic [31:0] tg_eva;
    logic [31:0] glb_eva;
    logic [31:0] eva_n;
    logic        invalid_n;

    assign is_host = ~dram_enable_i
                   & (32'(y_cord_i) == 32'd1)
                   & (32'(x_cord_i) == 32'd0)
                   & epa_i[addr_width_p-1];

    assign is_dram = (32'(y_cord_i) == 32'd0)
                   | (32'(y_cord_i) == 32'(num_tiles_y_p + 1));

    // A DRAM NPA is only invertible if it stays within one vcache's capacity.
    assign dram_epa_ok = ((32'(epa_i) >> lg_vcache_size_lp) == 32'd0);
    assign epa_lo_ok   = (32'(epa_i) < 32'h0001_0000);

    assign glb_ok = (32'(x_cord_i) < 32'd64)
                  & (32'(y_cord_i) < 32'd64)
                  & epa_lo_ok;

    assign host_eva = {2'b11, 1'b0, epa_i[26:0], 2'b00};
    assign glb_eva  = {2'b01, y_cord_i[5:0], x_cord_i[5:0], epa_i[15:0], 2'b00};

    always_comb begin
        dram_eva                                      = '0;
        dram_eva[31]                                  = 1'b1;
        dram_eva[bot_bit_lp]                          = (32'(y_cord_i) != 32'd0);
        dram_eva[2+lg_vcache_size_lp +: x_cord_width_p] = x_cord_i;
        dram_eva[2 +: lg_vcache_size_lp]              = epa_i[lg_vcache_size_lp-1:0];
    end

`ifdef BSG_MANYCORE_NPA_TO_EVA_TG_EN
    logic [x_cord_width_p-1:0] dx;
    logic [y_cord_width_p-1:0] dy;

    // Unsigned differences: a cord left of / above the origin wraps large and
    // therefore fails the dimension compare without a separate sign check.
    assign dx = x_cord_i - tgo_x_i;
    assign dy = y_cord_i - tgo_y_i;

    assign tg_hit = (dx < tg_dim_x_i)
                  & (dy < tg_dim_y_i)
                  & (32'(dx) < 32'd64)
                  & (32'(dy) < 32'd32)
                  & epa_lo_ok;
    assign tg_eva = {3'b001, dy[4:0], dx[5:0], epa_i[15:0], 2'b00};
`else
    logic unused_tg;

    assign unused_tg = ^{tgo_x_i, tgo_y_i, tg_dim_x_i, tg_dim_y_i};
    assign tg_hit    = 1'b0;
    assign tg_eva    = '0;
`endif

    // First match wins: host, DRAM, tile-group, global, else invalid.
    always_comb begin
        eva_n     = '0;
        invalid_n = 1'b0;
        if (is_host) begin
            eva_n = host_eva;
        end else if (is_dram) begin
            if (dram_enable_i | ~dram_epa_ok) begin
                invalid_n = 1'b1;
            end else begin
                eva_n = dram_eva;
            end
        end else if (tg_hit) begin
            eva_n = tg_eva;
        end else if (glb_ok) begin
            eva_n = glb_eva;
        end else begin
            invalid_n = 1'b1;
        end
    end

    assign ready_o = ~v_o | yumi_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v_o          <= 1'b0;
            eva_o        <= '0;
            is_invalid_o <= 1'b0;
        end else if (v_i & ready_o) begin
            v_o          <= 1'b1;
            eva_o        <= eva_n;
            is_invalid_o <= invalid_n;
        end else if (yumi_i) begin
            v_o          <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            invalid_count_o <= '0;
        end else if (v_o & yumi_i & is_invalid_o & (invalid_count_o != 8'hFF)) begin
            invalid_count_o <= invalid_count_o + 8'd1;
        end
    end

    yumi_requires_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);

endmodule

// File: tb/tb_bsg_manycore_npa_to_eva.sv
module tb_bsg_manycore_npa_to_eva;

    localparam int XW  = 7;
    localparam int YW  = 7;
    localparam int AW  = 28;
    localparam int NTY = 4;
    localparam int VC  = 1024;
    localparam int LG  = $clog2(VC);

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          v_i = 1'b0;
    logic [XW-1:0] x_cord_i = '0;
    logic [YW-1:0] y_cord_i = '0;
    logic [AW-1:0] epa_i = '0;
    logic          ready_o;
    logic [XW-1:0] tgo_x_i = '0;
    logic [YW-1:0] tgo_y_i = '0;
    logic [XW-1:0] tg_dim_x_i = '0;
    logic [YW-1:0] tg_dim_y_i = '0;
    logic          dram_enable_i = 1'b0;
    logic          v_o;
    logic [31:0]   eva_o;
    logic          is_invalid_o;
    logic          yumi_i = 1'b0;
    logic [7:0]    invalid_count_o;

    int checks   = 0;
    int failures = 0;

    // Reference state: one held entry plus the consumed-invalid counter.
    bit          mdl_full = 1'b0;
    logic [31:0] mdl_eva  = '0;
    bit          mdl_inv  = 1'b0;
    int          mdl_cnt  = 0;

    always #5 clk_i = ~clk_i;

    bsg_manycore_npa_to_eva #(
        .data_width_p  (32),
        .addr_width_p  (AW),
        .x_cord_width_p(XW),
        .y_cord_width_p(YW),
        .num_tiles_y_p (NTY),
        .vcache_size_p (VC)
    ) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .v_i            (v_i),
        .x_cord_i       (x_cord_i),
        .y_cord_i       (y_cord_i),
        .epa_i          (epa_i),
        .ready_o        (ready_o),
        .tgo_x_i        (tgo_x_i),
        .tgo_y_i        (tgo_y_i),
        .tg_dim_x_i     (tg_dim_x_i),
        .tg_dim_y_i     (tg_dim_y_i),
        .dram_enable_i  (dram_enable_i),
        .v_o            (v_o),
        .eva_o          (eva_o),
        .is_invalid_o   (is_invalid_o),
        .yumi_i         (yumi_i),
        .invalid_count_o(invalid_count_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Returns {invalid, eva} computed from the address-map rules with plain arithmetic.
    function automatic logic [32:0] npa2eva(input longint x, input longint y, input longint epa,
                                            input longint tgox, input longint tgoy,
                                            input longint dimx, input longint dimy, input bit den);
        longint dx;
        longint dy;
        longint r;
        dx = (x - tgox + 128) % 128;
        dy = (y - tgoy + 128) % 128;
        if (!den && y == 1 && x == 0 && epa >= (64'd1 << 27)) begin
            r = 64'hC000_0000 + (epa - (64'd1 << 27)) * 4;
            return {1'b0, 32'(r)};
        end
        if (y == 0 || y == NTY + 1) begin
            if (den || epa >= VC) return {1'b1, 32'h0};
            r = 64'h8000_0000 + ((y != 0) ? (64'd1 << (2 + LG + XW)) : 64'd0)
                + x * (64'd1 << (2 + LG)) + epa * 4;
            return {1'b0, 32'(r)};
        end
`ifdef BSG_MANYCORE_NPA_TO_EVA_TG_EN
        if (dx < dimx && dy < dimy && dx < 64 && dy < 32 && epa < 65536) begin
            r = 64'h2000_0000 + dy * (64'd1 << 24) + dx * (64'd1 << 18) + epa * 4;
            return {1'b0, 32'(r)};
        end
`endif
        if (x < 64 && y < 64 && epa < 65536) begin
            r = 64'h4000_0000 + y * (64'd1 << 24) + x * (64'd1 << 18) + epa * 4;
            return {1'b0, 32'(r)};
        end
        return {1'b1, 32'h0};
    endfunction

    // One clock cycle: check the outputs of the previous edge against the model,
    // drive new inputs, then advance the model to what the next edge must produce.
    task automatic step(input bit rst, input bit v, input int x, input int y, input int epa,
                        input int tgox, input int tgoy, input int dimx, input int dimy,
                        input bit den, input bit want_yumi);
        bit acc;
        logic [32:0] r;
        @(negedge clk_i);
        chk("v_o", 32'(v_o), 32'(mdl_full));
        chk("invalid_count_o", 32'(invalid_count_o), 32'(mdl_cnt));
        if (mdl_full) begin
            chk("eva_o", eva_o, mdl_eva);
            chk("is_invalid_o", 32'(is_invalid_o), 32'(mdl_inv));
        end
        reset_i       = rst;
        v_i           = v;
        x_cord_i      = XW'(x);
        y_cord_i      = YW'(y);
        epa_i         = AW'(epa);
        tgo_x_i       = XW'(tgox);
        tgo_y_i       = YW'(tgoy);
        tg_dim_x_i    = XW'(dimx);
        tg_dim_y_i    = YW'(dimy);
        dram_enable_i = den;
        yumi_i        = want_yumi & mdl_full & ~rst;
        #1;
        chk("ready_o", 32'(ready_o), 32'(!mdl_full || yumi_i));
        if (rst) begin
            mdl_full = 1'b0;
            mdl_cnt  = 0;
        end else begin
            acc = v && (!mdl_full || yumi_i);
            if (yumi_i) begin
                if (mdl_inv && mdl_cnt < 255) mdl_cnt++;
                mdl_full = 1'b0;
            end
            if (acc) begin
                r        = npa2eva(x, y, epa, tgox, tgoy, dimx, dimy, den);
                mdl_full = 1'b1;
                mdl_inv  = r[32];
                mdl_eva  = r[31:0];
            end
        end
    endtask

    task automatic idle(input bit want_yumi);
        step(1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b0, want_yumi);
    endtask

    initial begin
        int x, y, epa, sel;

        // Hand-computed values pinning the reference model.
        chk("pin_global", npa2eva(3, 2, 16'h0010, 0, 0, 0, 0, 1'b0), {1'b0, 32'h420C_0040});
        chk("pin_dram_bot", npa2eva(1, 5, 5, 0, 0, 0, 0, 1'b0), {1'b0, 32'h8008_1014});
        chk("pin_dram_top", npa2eva(2, 0, 3, 0, 0, 0, 0, 1'b0), {1'b0, 32'h8000_200C});
        chk("pin_dram_striped", npa2eva(1, 5, 5, 0, 0, 0, 0, 1'b1), {1'b1, 32'h0});
        chk("pin_host", npa2eva(0, 1, (1 << 27) + 5, 0, 0, 0, 0, 1'b0), {1'b0, 32'hC000_0014});
`ifdef BSG_MANYCORE_NPA_TO_EVA_TG_EN
        chk("pin_tg", npa2eva(3, 2, 0, 2, 1, 4, 4, 1'b0), {1'b0, 32'h2104_0000});
`else
        chk("pin_tg_off", npa2eva(3, 2, 0, 2, 1, 4, 4, 1'b0), {1'b0, 32'h420C_0000});
`endif
        chk("pin_tg_outside", npa2eva(6, 2, 0, 2, 1, 4, 4, 1'b0), {1'b0, 32'h4218_0000});

        // Reset, then idle.
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        chk("rst_v_o", 32'(v_o), 32'd0);
        chk("rst_eva_o", eva_o, 32'd0);
        chk("rst_is_invalid_o", 32'(is_invalid_o), 32'd0);
        chk("rst_count", 32'(invalid_count_o), 32'd0);
        chk("rst_ready_o", 32'(ready_o), 32'd1);
        idle(1'b0);
        idle(1'b0);

        // Global translation, one cycle latency.
        step(1'b0, 1'b1, 3, 2, 16'h0010, 0, 0, 0, 0, 1'b0, 1'b0);
        idle(1'b1);
        chk("dir_global", eva_o, 32'h420C_0040);

        // Tile-group inside / outside.
        step(1'b0, 1'b1, 3, 2, 0, 2, 1, 4, 4, 1'b0, 1'b0);
        step(1'b0, 1'b1, 6, 2, 0, 2, 1, 4, 4, 1'b0, 1'b1);
        idle(1'b1);
        chk("dir_tg_outside", eva_o, 32'h4218_0000);

        // DRAM, bottom row, then the same NPA in striped mode.
        step(1'b0, 1'b1, 1, 5, 5, 0, 0, 0, 0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1, 5, 5, 0, 0, 0, 0, 1'b1, 1'b1);
        idle(1'b1);
        chk("dir_dram_invalid", 32'(is_invalid_o), 32'd1);
        chk("dir_dram_inv_eva", eva_o, 32'd0);
        idle(1'b0);

        // Backpressure: three back-to-back offers with the consumer stalled.
        step(1'b0, 1'b1, 10, 3, 100, 0, 0, 0, 0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 11, 4, 200, 0, 0, 0, 0, 1'b0, 1'b0);
        chk("bp_ready_full", 32'(ready_o), 32'd0);
        step(1'b0, 1'b1, 11, 4, 200, 0, 0, 0, 0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 11, 4, 200, 0, 0, 0, 0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 12, 6, 300, 0, 0, 0, 0, 1'b0, 1'b1);
        idle(1'b1);
        chk("bp_third", eva_o, 32'h4630_04B0);
        idle(1'b0);

        // Randomized traffic with random consumer stalls.
        for (int i = 0; i < 2000; i++) begin
            sel = $urandom_range(0, 5);
            x   = $urandom_range(0, 127);
            y   = (sel == 0) ? 0 : (sel == 1) ? NTY + 1 : (sel == 2) ? 1 : $urandom_range(0, 127);
            if (sel == 2 && $urandom_range(0, 1) == 1) x = 0;
            case ($urandom_range(0, 3))
                0: epa = $urandom_range(0, VC - 1);
                1: epa = $urandom_range(0, 65535);
                2: epa = (1 << 27) + $urandom_range(0, 1000);
                default: epa = int'($urandom_range(0, (1 << 28) - 1));
            endcase
            step(1'b0, 1'($urandom_range(0, 3) != 0), x, y, epa,
                 $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 15), $urandom_range(0, 15),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) != 0));
        end
        idle(1'b1);
        idle(1'b0);

        // Counter saturation with full-throughput invalid traffic.
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 1'b1, 100, 40, 0, 0, 0, 0, 0, 1'b0, 1'b1);
        end
        idle(1'b1);
        idle(1'b0);
        chk("sat_count", 32'(invalid_count_o), 32'hFF);

        // Reset while an entry is held.
        step(1'b0, 1'b1, 3, 2, 16, 0, 0, 0, 0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        idle(1'b0);
        chk("midrst_v_o", 32'(v_o), 32'd0);
        chk("midrst_count", 32'(invalid_count_o), 32'd0);
        idle(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
